// File: rtl/alu_exec_unit.sv
// EX-stage ALU execution unit: single-cycle logic/arithmetic/set ops and
// iterative one-bit-per-cycle shifts, with a registered result and done pulse.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       decoded_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // state   | meaning
  // S_IDLE  | accepting ops; single-cycle ops and zero-amount shifts finish here
  // S_SHIFT | shifting the accumulator one bit per cycle until cnt reaches 0
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  typedef enum logic [1:0] {SH_LL = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2} shkind_t;

  localparam logic [5:0] OP_BEQZ = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h08;
  localparam logic [5:0] OP_SUB  = 6'h0a;
  localparam logic [5:0] OP_AND  = 6'h0c;
  localparam logic [5:0] OP_OR   = 6'h0d;
  localparam logic [5:0] OP_XOR  = 6'h0e;
  localparam logic [5:0] OP_SLL  = 6'h14;
  localparam logic [5:0] OP_SRL  = 6'h16;
  localparam logic [5:0] OP_SRA  = 6'h17;
  localparam logic [5:0] OP_SEQ  = 6'h18;
  localparam logic [5:0] OP_SNE  = 6'h19;
  localparam logic [5:0] OP_SLT  = 6'h1a;
  localparam logic [5:0] OP_SLE  = 6'h1c;

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  shkind_t            r_kind, w_kind_nxt, w_op_kind;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt, w_acc_shifted;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic               r_zero, w_zero_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic               r_done, w_done_nxt;

  logic [SHAMT_W-1:0] w_amt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_legal;
  logic               w_is_shift;
  logic               w_set_bit;

  assign w_amt = operand_b[SHAMT_W-1:0];

  // Single-cycle datapath; a zero-amount shift just passes operand_a through.
  always_comb begin
    w_alu_res  = '0;
    w_legal    = 1'b1;
    w_is_shift = 1'b0;
    w_set_bit  = 1'b0;
    w_op_kind  = SH_LL;
    case (decoded_op)
      OP_BEQZ: w_set_bit = (operand_a == '0);
      OP_SEQ:  w_set_bit = (operand_a == operand_b);
      OP_SNE:  w_set_bit = (operand_a != operand_b);
      OP_SLT:  w_set_bit = ($signed(operand_a) <  $signed(operand_b));
      OP_SLE:  w_set_bit = ($signed(operand_a) <= $signed(operand_b));
      OP_ADD:  w_alu_res = operand_a + operand_b;
      OP_SUB:  w_alu_res = operand_a - operand_b;
      OP_AND:  w_alu_res = operand_a & operand_b;
      OP_OR:   w_alu_res = operand_a | operand_b;
      OP_XOR:  w_alu_res = operand_a ^ operand_b;
      OP_SLL: begin
        w_is_shift = 1'b1;
        w_op_kind  = SH_LL;
        w_alu_res  = operand_a;
      end
      OP_SRL: begin
        w_is_shift = 1'b1;
        w_op_kind  = SH_RL;
        w_alu_res  = operand_a;
      end
      OP_SRA: begin
        w_is_shift = 1'b1;
        w_op_kind  = SH_RA;
        w_alu_res  = operand_a;
      end
      default: w_legal = 1'b0;
    endcase
    if (decoded_op == OP_BEQZ || decoded_op == OP_SEQ || decoded_op == OP_SNE ||
        decoded_op == OP_SLT  || decoded_op == OP_SLE)
      w_alu_res = {{(WIDTH-1){1'b0}}, w_set_bit};
  end

  always_comb begin
    w_acc_shifted = r_acc;
    case (r_kind)
      SH_LL:   w_acc_shifted = {r_acc[WIDTH-2:0], 1'b0};
      SH_RL:   w_acc_shifted = {1'b0, r_acc[WIDTH-1:1]};
      SH_RA:   w_acc_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_acc_shifted = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_kind_nxt    = r_kind;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_result_nxt  = r_result;
    w_zero_nxt    = r_zero;
    w_illegal_nxt = r_illegal;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_is_shift && (w_amt != '0)) begin
            w_acc_nxt   = operand_a;
            w_cnt_nxt   = w_amt;
            w_kind_nxt  = w_op_kind;
            w_state_nxt = S_SHIFT;
          end else begin
            w_result_nxt  = w_alu_res;
            w_zero_nxt    = (w_alu_res == '0);
            w_illegal_nxt = ~w_legal;
            w_done_nxt    = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        w_acc_nxt = w_acc_shifted;
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_result_nxt  = w_acc_shifted;
          w_zero_nxt    = (w_acc_shifted == '0);
          w_illegal_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_kind    <= SH_LL;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_kind    <= w_kind_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_result  <= w_result_nxt;
      r_zero    <= w_zero_nxt;
      r_illegal <= w_illegal_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy    = (r_state == S_SHIFT);
  assign done    = r_done;
  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: scoreboard of expected completions popped
// on each done pulse, plus latency/busy/reset checks.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  decoded_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .decoded_op (decoded_op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run      = 0;
  int   max_run  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    n     = int'(b[4:0]);
    e.ill = 1'b0;
    case (op)
      6'h00: e.res = (a == 32'd0) ? 32'd1 : 32'd0;
      6'h08: e.res = a + b;
      6'h0a: e.res = a - b;
      6'h0c: e.res = a & b;
      6'h0d: e.res = a | b;
      6'h0e: e.res = a ^ b;
      6'h18: e.res = (a == b) ? 32'd1 : 32'd0;
      6'h19: e.res = (a != b) ? 32'd1 : 32'd0;
      6'h1a: e.res = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      6'h1c: e.res = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      6'h14: e.res = a << n;
      6'h16: e.res = a >> n;
      6'h17: e.res = 32'($signed(a) >>> n);
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      run++;
      if (run > max_run) max_run = run;
      chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_zero", 32'(zero), 32'(e.zero));
        chk("sb_illegal", 32'(illegal), 32'(e.ill));
      end
    end else begin
      run = 0;
    end
  end

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    decoded_op = op;
    operand_a  = a;
    operand_b  = b;
    start      = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
  endtask

  // Counts negedges until done; optionally pulses an ADD 1+1 start at cycle inj_at.
  task automatic wait_done(input int budget, input int inj_at, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) break;
      if (lat == inj_at) begin
        decoded_op = 6'h08;
        operand_a  = 32'd1;
        operand_b  = 32'd1;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int nb;
    rst_n      = 1'b0;
    start      = 1'b0;
    decoded_op = 6'h00;
    operand_a  = 32'd0;
    operand_b  = 32'd0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back single-cycle ops
    max_run = 0;
    drive(6'h08, 32'd5, 32'hFFFF_FFFD);
    drive(6'h1a, 32'hFFFF_FFFF, 32'd1);
    drive(6'h0a, 32'd7, 32'd7);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_done_run", 32'(max_run), 32'd3);
    chk("b2b_zero_held", 32'(zero), 32'd1);

    // more single-cycle patterns
    drive(6'h0e, 32'hA5A5_0F0F, 32'hFFFF_0000);
    start = 1'b0;
    wait_done(5, 0, lat, nb);
    chk("xor_latency", 32'(lat), 32'd1);
    drive(6'h1c, 32'h8000_0000, 32'h8000_0000);
    start = 1'b0;
    wait_done(5, 0, lat, nb);

    // SRA with an ignored start while busy
    drive(6'h17, 32'h8000_0000, 32'd4);
    start = 1'b0;
    wait_done(20, 2, lat, nb);
    chk("sra_latency", 32'(lat), 32'd5);
    chk("sra_busy_cycles", 32'(nb), 32'd4);
    chk("sra_result", result, 32'hF800_0000);
    repeat (3) @(negedge clk);
    chk("sra_no_extra_result", 32'(result != 32'd2), 32'd1);

    // zero-amount and maximum shifts
    drive(6'h14, 32'h0000_1234, 32'd0);
    start = 1'b0;
    wait_done(5, 0, lat, nb);
    chk("sll0_latency", 32'(lat), 32'd1);
    chk("sll0_busy_cycles", 32'(nb), 32'd0);
    drive(6'h16, 32'hFFFF_FFFF, 32'd31);
    start = 1'b0;
    wait_done(50, 0, lat, nb);
    chk("srl31_latency", 32'(lat), 32'd32);
    chk("srl31_busy_cycles", 32'(nb), 32'd31);
    chk("srl31_result", result, 32'd1);

    // illegal op then BEQZ, issued back to back
    drive(6'h3F, 32'h1234_5678, 32'd9);
    start = 1'b0;
    wait_done(5, 0, lat, nb);
    chk("illegal_latency", 32'(lat), 32'd1);
    chk("illegal_flag", 32'(illegal), 32'd1);
    drive(6'h00, 32'd0, 32'd0);
    start = 1'b0;
    wait_done(5, 0, lat, nb);
    chk("beqz_illegal_clear", 32'(illegal), 32'd0);

    // reset in the middle of a shift
    drive(6'h14, 32'd1, 32'd20);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midshift_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("postrst_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    drive(6'h08, 32'd3, 32'd4);
    start = 1'b0;
    wait_done(5, 0, lat, nb);
    chk("add_after_rst_latency", 32'(lat), 32'd1);
    chk("add_after_rst_result", result, 32'd7);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution end of the ALU-op encoding produced by the ALU control decoder.
- Takes a 6-bit decoded ALU operation code and two operands, and produces a registered result with a one-cycle done pulse.
- Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, to keep the barrel shifter out of the EX path.
- Sits in the EX stage, between the ALU control decoder and the EX/MEM register.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; uses operand_b[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled on the rising edge.
- decoded_op  in  6  decoded ALU op code; encoding below.
- operand_a  in  WIDTH  first operand; the shift source.
- operand_b  in  WIDTH  second operand; supplies the shift amount.
- busy  out  1  high while an iterative shift is in progress.
- done  out  1  one-cycle pulse: result, zero and illegal are valid.
- result  out  WIDTH  registered result; held until the next completion.
- zero  out  1  registered (result == 0), updated with result.
- illegal  out  1  registered; op code not in the table below.

Behaviour:
- Op encoding (hex):
  - 00 BEQZ: result = (a==0) ? 1 : 0
  - 08 ADD: a+b, modulo 2^WIDTH, no overflow trap
  - 0a SUB: a-b
  - 0c AND, 0d OR, 0e XOR: bitwise
  - 18 SEQ: a==b
  - 19 SNE: a!=b
  - 1a SLT: signed a<b
  - 1c SLE: signed a<=b
  - 14 SLL, 16 SRL (zero fill), 17 SRA (sign fill)
  - Set-type ops return 1 or 0, zero-extended to WIDTH.
- Reset (async, rst_n low):
  - state=IDLE; result=0, zero=0, illegal=0, done=0, busy=0.
  - Shift accumulator and counter cleared.
  - Takes effect immediately, including mid-shift. The aborted op produces no done.
- State IDLE:
  - start=1 with a non-shift op, or a shift op with amount 0: at that edge, register result/zero/illegal, done=1 in the next cycle, stay IDLE. Latency is 1 cycle, so back-to-back issue every cycle is allowed.
  - start=1 with a shift op, amount n>=1: latch operand_a into the accumulator, the op, and cnt=n. Go to SHIFT, busy=1 from the next cycle. result keeps its old value. done stays 0.
  - start=0: done=0; all other outputs hold.
- State SHIFT:
  - Each edge shifts the accumulator one bit in the latched direction (SRA replicates the MSB) and decrements cnt.
  - At the edge where cnt goes 1->0: result and zero take the final accumulator value, illegal=0, done=1 for one cycle, return to IDLE.
  - Latency for amount n is n+1 cycles from the accepting edge. busy is high for exactly n cycles.
- start while busy: ignored, not queued. Operands may change freely during SHIFT.
- start in the done cycle after a shift: accepted normally, since the block is already in IDLE.
- Unknown op code: result=0, zero=1, illegal=1, done pulses after 1 cycle. Never enters SHIFT.
- busy = (state==SHIFT), registered state decode with no combinational path from start.
- done is never high for two consecutive cycles for the same op. It is high in consecutive cycles only for back-to-back single-cycle ops.

Test Plan:
- Reset then idle:
  - rst_n low mid-clock -> result=0, done=0, busy=0, illegal=0 immediately, without waiting for a clock edge.
- Back-to-back single-cycle ops, issued on consecutive cycles:
  - start with ADD a=5, b=0xFFFFFFFD -> done=1 next cycle, result=2, zero=0.
  - then SLT a=0xFFFFFFFF, b=1 -> result=1.
  - then SUB a=7, b=7 -> result=0, zero=1.
  - Required: done high for 3 consecutive cycles.
- SRA iterative shift:
  - a=0x80000000, b=4 -> busy high for 4 cycles, done on cycle 5, result=0xF8000000.
  - A start (ADD 1+1) asserted during busy is ignored: no extra done, result never 2.
- Zero-amount and maximum shifts:
  - SLL a=0x1234, b=0 -> done after 1 cycle, busy never high, result=0x1234.
  - SRL a=0xFFFFFFFF, b=31 -> done after 32 cycles, result=1.
- Unknown op and BEQZ:
  - op=0x3F -> done after 1 cycle, illegal=1, result=0, zero=1.
  - then BEQZ a=0 -> result=1, illegal=0.
- Reset mid-shift:
  - SLL b=20, assert rst_n low after 10 cycles -> busy=0 and result=0 immediately, no done pulse.
  - After release, ADD 3+4 -> result=7 one cycle later.
